// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing outputs from the timing generator to renderer and VGA pins
interface vga_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           H_Sync;
    logic           V_Sync;
    logic           Display;
    logic [X_W-1:0] X_Coord;
    logic [Y_W-1:0] Y_Coord;
    logic           Line_Start;
    logic           Frame_Start;
    modport master (output H_Sync, V_Sync, Display, X_Coord, Y_Coord, Line_Start, Frame_Start);
    modport slave  (input  H_Sync, V_Sync, Display, X_Coord, Y_Coord, Line_Start, Frame_Start);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing; define VGA_TIMING_LOOKAHEAD_EN to lead Display/X/Y by one pixel
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic HP = H_POL[0];
    localparam logic VP = V_POL[0];

    logic [HW-1:0] h, hn, dh;
    logic [VW-1:0] v, vn, dv;
    logic          h_act, v_act;

    assign hn = (h == H_LAST) ? '0 : h + HW'(1);
    assign vn = (h != H_LAST) ? v : ((v == V_LAST) ? '0 : v + VW'(1));

    // Pixel-data decode position: one pixel ahead lets a registered pixel stage line up with sync
`ifdef VGA_TIMING_LOOKAHEAD_EN
    assign dh = hn;
    assign dv = vn;
`else
    assign dh = h;
    assign dv = v;
`endif

    assign h_act = (dh >= H_ACT_BEG) && (dh <= H_ACT_LAST);
    assign v_act = (dv >= V_ACT_BEG) && (dv <= V_ACT_LAST);

    // Raster position: h sweeps every pixel, v advances on each h wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= hn;
            v <= vn;
        end
    end

    // Registered decode of the current position keeps all outputs mutually aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga.H_Sync      <= ~HP;
            vga.V_Sync      <= ~VP;
            vga.Display     <= 1'b0;
            vga.X_Coord     <= '0;
            vga.Y_Coord     <= '0;
            vga.Line_Start  <= 1'b0;
            vga.Frame_Start <= 1'b0;
        end else begin
            vga.H_Sync      <= (h < H_SYNC_END) ? HP : ~HP;
            vga.V_Sync      <= (v < V_SYNC_END) ? VP : ~VP;
            vga.Display     <= h_act && v_act;
            vga.X_Coord     <= h_act ? X_W'(dh - H_ACT_BEG) : '0;
            vga.Y_Coord     <= v_act ? Y_W'(dv - V_ACT_BEG) : '0;
            vga.Line_Start  <= (h == '0);
            vga.Frame_Start <= (h == '0) && (v == '0);
        end
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator producing horizontal sync, vertical sync, display enable, pixel coordinates and frame/line strobes from a single pixel clock. Generalises the fixed 640x480 vertical-sync block: line-based vertical counting, programmable porch/sync/active widths and sync polarity, and registered frame and line start strobes. Sits between the 25 MHz pixel clock and the pixel/sprite renderer and VGA pins.

## Interface
- H_SYNC, 96: horizontal sync width, pixels
- H_BACK, 48: horizontal back porch, pixels
- H_ACTIVE, 640: horizontal active pixels
- H_FRONT, 16: horizontal front porch, pixels
- V_SYNC, 2: vertical sync width, lines
- V_BACK, 33: vertical back porch, lines
- V_ACTIVE, 480: vertical active lines
- V_FRONT, 10: vertical front porch, lines
- H_POL, 0: H_Sync active level (0 = active-low)
- V_POL, 0: V_Sync active level (0 = active-low)
- X_W, 10: X_Coord width; Y_W, 10: Y_Coord width
- clk  in  1  pixel clock (25 MHz at defaults)
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- H_Sync  out  1  horizontal sync, level per H_POL
- V_Sync  out  1  vertical sync, level per V_POL
- Display  out  1  high when pixel is in both active regions
- X_Coord  out  X_W  active pixel column, 0..H_ACTIVE-1
- Y_Coord  out  Y_W  active line, 0..V_ACTIVE-1
- Line_Start  out  1  one-cycle pulse at pixel 0 of every line
- Frame_Start  out  1  one-cycle pulse at pixel 0 of line 0

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT.
- Internal h counter 0..H_TOTAL-1, increments every clk, wraps to 0. v counter 0..V_TOTAL-1, increments only when h wraps, wraps to 0 when h and v both at terminal count.
- Region order per axis: sync, back porch, active, front porch. Sync active: h < H_SYNC (resp. v < V_SYNC).
- H active: H_SYNC+H_BACK <= h < H_SYNC+H_BACK+H_ACTIVE; V active likewise.
- X_Coord = h-(H_SYNC+H_BACK) when H active, else 0.
- Y_Coord = v-(V_SYNC+V_BACK) when V active (held across horizontal blanking), else 0.
- Display = H active AND V active.
- Line_Start high when h==0; Frame_Start high when h==0 and v==0.
- Counter widths sized with $clog2(H_TOTAL)/$clog2(V_TOTAL); no overflow beyond terminal count.

## Timing
- All outputs registered; each output at cycle t is the decode of counter position held at t-1 (one-cycle latency, uniform across outputs, so sync/display/coords stay mutually aligned).
- Reset (async assert): h=0, v=0, H_Sync=!H_POL, V_Sync=!V_POL, Display=0, X_Coord=0, Y_Coord=0, Line_Start=0, Frame_Start=0.
- First rising edge after rst deasserts: outputs show position (0,0): H_Sync/V_Sync active, Line_Start=1, Frame_Start=1.
- Frame period exactly H_TOTAL*V_TOTAL cycles (420000 at defaults); line period H_TOTAL (800).
- Reset asserted mid-frame: immediate return to reset values; next frame restarts at (0,0), no partial-frame resumption.
- Simultaneous h and v wrap: both counters return to 0 on the same edge.

## Configuration
- VGA_TIMING_LOOKAHEAD_EN defined: Display, X_Coord, Y_Coord decoded from position one pixel ahead (h+1, carrying into v, wrapping at frame end); they lead H_Sync/V_Sync/strobes by one cycle so a registered pixel pipeline stage lines up with sync. Reset values unchanged.
- Not defined: all outputs aligned as in Timing.

## Test plan
- Small params H 2/2/4/2, V 1/1/3/1 (H_TOTAL 10, V_TOTAL 6), release reset -> Frame_Start pulses every 60 cycles, Line_Start every 10, H_Sync low for 2 of 10 cycles.
- Same params -> Display high 4 consecutive cycles on lines 2..4 only; X_Coord 0,1,2,3 during them; Y_Coord 0,1,2 on those lines; 12 Display cycles per frame.
- Defaults -> V_Sync low for exactly 1600 cycles per 420000-cycle frame; Y_Coord reaches 479, X_Coord reaches 639, never exceed.
- H_POL=1, V_POL=1 -> sync pulses high, idle low; reset value of both syncs 0.
- Assert rst for 3 cycles mid-active line (line 3, pixel 5 in small params) -> outputs to reset values asynchronously; first edge after release Frame_Start=1.
- With VGA_TIMING_LOOKAHEAD_EN, small params -> Display rises one cycle earlier relative to Line_Start than without (cycle 3 vs 4 of the line).
